// File: rtl/shift_pkg.sv
// Shared types and defaults for the iterative shift unit.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned SHAMT_W_DEF = 5;

endpackage

// File: rtl/shift_stage.sv
// One conditional power-of-two shift stage; the stage index selects 2^index.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [XLEN-1:0]  value,
    input  logic [IDX_W-1:0] index,
    input  logic             enable,
    input  logic             direct,
    input  logic             arithmetic,
    output logic [XLEN-1:0]  result
);

    logic [SHAMT_W-1:0] amt;

    always_comb begin
        amt    = SHAMT_W'(1) << index;
        result = value;
        if (enable) begin
            if (direct == DIR_LEFT) begin
                result = value << amt;
            end else if (arithmetic) begin
                result = $signed(value) >>> amt;
            end else begin
                result = value >> amt;
            end
        end
    end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle SLL/SRL/SRA unit: one shamt bit per clock over a valid/ready interface.
module shift_iter
    import shift_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [XLEN-1:0]    value_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               direct_i,
    input  logic               arithmetic_i,
    input  logic               kill_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    value_o
);

    localparam int unsigned CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SHAMT_W-1:0] shamt_q;
    logic               dir_q;
    logic               arith_q;
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    stage_out;

    shift_stage #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W),
        .IDX_W   (CNT_W)
    ) u_stage (
        .value      (acc),
        .index      (cnt),
        .enable     (shamt_q[cnt]),
        .direct     (dir_q),
        .arithmetic (arith_q),
        .result     (stage_out)
    );

    // A kill leaves the accumulator untouched; the result is dropped by leaving DONE unvisited.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            shamt_q <= '0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
            acc     <= '0;
        end else if (kill_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        acc     <= value_i;
                        shamt_q <= shamt_i;
                        dir_q   <= direct_i;
                        arith_q <= arithmetic_i;
                        cnt     <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= stage_out;
                    if (cnt == CNT_W'(SHAMT_W - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign value_o = acc;

endmodule

// File: tb/tb_shift_iter.sv
// Directed self-checking bench for shift_iter.
module tb_shift_iter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] value_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        direct_i = 1'b0;
    logic        arithmetic_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] value_o;

    int tests_run = 0;
    int tests_failed = 0;

    shift_iter #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .value_i      (value_i),
        .shamt_i      (shamt_i),
        .direct_i     (direct_i),
        .arithmetic_i (arithmetic_i),
        .kill_i       (kill_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .value_o      (value_o)
    );

    always #5 clk_i = ~clk_i;

    // All tasks start and end 1ns after a rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_op(input logic [31:0] v, input logic [4:0] sh,
                            input logic dir, input logic ar);
        value_i      = v;
        shamt_i      = sh;
        direct_i     = dir;
        arithmetic_i = ar;
        valid_i      = 1'b1;
        step();
        valid_i      = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!valid_o && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic finish_op();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || value_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got ready=%b valid=%b value=%h expected 1 0 00000000",
                     ready_o, valid_o, value_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_sll_latency();
        int n;
        start_op(32'h0000_0001, 5'd31, 1'b0, 1'b0);
        wait_done(n);
        tests_run++;
        if (n !== 5) begin
            tests_failed++;
            $display("FAIL sll_latency: got %0d cycles expected 5", n);
        end
        tests_run++;
        if (value_o !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL sll_value: got %h expected 80000000", value_o);
        end
        ready_i = 1'b1;
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_no_turnaround: got ready_o=%b expected 0", ready_o);
        end
        step();
        ready_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_handshake: got ready=%b valid=%b expected 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] vin [4]  = '{32'h8000_0000, 32'h8000_0000, 32'hF000_0000, 32'hDEAD_BEEF};
        logic [4:0]  sh [4]   = '{5'd4, 5'd4, 5'd28, 5'd0};
        logic        dir [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        ar [4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp [4]  = '{32'hF800_0000, 32'h0800_0000, 32'h0000_000F, 32'hDEAD_BEEF};
        int n;
        for (int i = 0; i < 4; i++) begin
            start_op(vin[i], sh[i], dir[i], ar[i]);
            wait_done(n);
            tests_run++;
            if (n !== 5 || value_o !== exp[i]) begin
                tests_failed++;
                $display("FAIL shift_vec%0d: got %h after %0d cycles expected %h after 5",
                         i, value_o, n, exp[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int n;
        start_op(32'h0000_0005, 5'd2, 1'b0, 1'b0);
        wait_done(n);
        value_i = 32'h1111_1111;
        shamt_i = 5'd1;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (valid_o !== 1'b1 || value_o !== 32'h0000_0014 || ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: got valid=%b value=%h ready=%b expected 1 00000014 0",
                         i, valid_o, value_o, ready_o);
            end
            step();
        end
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: got ready=%b valid=%b expected 1 0", ready_o, valid_o);
        end
        valid_i = 1'b0;
        step();
    endtask

    task automatic test_kill();
        int n;
        int pulses = 0;
        start_op(32'h0000_00FF, 5'd3, 1'b0, 1'b0);
        step();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL kill_idle: got ready=%b valid=%b expected 1 0", ready_o, valid_o);
        end
        for (int i = 0; i < 6; i++) begin
            if (valid_o) pulses++;
            step();
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL kill_no_valid: got %0d valid cycles expected 0", pulses);
        end
        value_i = 32'h0000_0042;
        valid_i = 1'b1;
        kill_i  = 1'b1;
        step();
        valid_i = 1'b0;
        kill_i  = 1'b0;
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL kill_blocks_accept: got ready=%b expected 1", ready_o);
        end
        start_op(32'h0000_0003, 5'd1, 1'b0, 1'b0);
        wait_done(n);
        tests_run++;
        if (n !== 5 || value_o !== 32'h0000_0006) begin
            tests_failed++;
            $display("FAIL kill_next_op: got %h after %0d cycles expected 00000006 after 5", value_o, n);
        end
        finish_op();
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(32'h1234_5678, 5'd7, 1'b0, 1'b0);
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || value_o !== 32'h0 || ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b value=%h ready=%b expected 0 00000000 1",
                     valid_o, value_o, ready_o);
        end
        #1;
        rst_ni = 1'b1;
        step();
        start_op(32'hFFFF_FF00, 5'd8, 1'b1, 1'b1);
        wait_done(n);
        tests_run++;
        if (n !== 5 || value_o !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL post_reset_sra: got %h after %0d cycles expected ffffffff after 5", value_o, n);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_sll_latency();
        test_shifts();
        test_backpressure();
        test_kill();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
